// File: rtl/gfe_dot_ctrl.sv
// GF(3) dot-product sequencer over LEN operand pairs, sharing one mod-3 Barrett reducer.
// Latency: 3 cycles per pair (LOAD, MUL, ACC) plus LOAD stalls; done pulses 3*LEN cycles after start.
// Backpressure: in_ready is high only in LOAD; a pair is consumed on in_valid && in_ready.

// Mod-3 Barrett reduction for a 3-bit input: q = (x*5)>>4, r = x - 3q, one conditional correction.
module GFE_barret (
  input  logic [2:0] x_i,
  output logic [1:0] r_o
);

  logic [5:0] prod;
  logic [1:0] q;
  logic [2:0] qx3;
  logic [2:0] rem;

  // Quotient estimate, remainder, and the single correction step the estimate can require
  always_comb begin
    prod = {3'b000, x_i} * 6'd5;
    q    = 2'(prod >> 4);
    qx3  = {1'b0, q} + {q, 1'b0};
    rem  = x_i - qx3;
    if (rem >= 3'd3) begin
      rem = rem - 3'd3;
    end
    r_o  = rem[1:0];
  end

endmodule

module gfe_dot_ctrl #(
  parameter int LEN = 4,
  parameter int CW  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       busy,
  output logic       done,
  output logic [1:0] result
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MUL  = 3'd2,
    S_ACC  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  state_t        state_q;
  logic [1:0]    ra_q, rb_q, p_q, acc_q, result_q;
  logic [CW-1:0] cnt_q;
  logic          in_ready_q, busy_q, done_q;
  logic [2:0]    red_in_d;
  logic [1:0]    red_out;

  // Operand value 3 is congruent to 0, so it is folded at capture
  function automatic logic [1:0] norm(input logic [1:0] v);
    return (v == 2'b11) ? 2'b00 : v;
  endfunction

  // Reducer input: product in MUL, accumulate in ACC, idle-zero otherwise
  always_comb begin
    red_in_d = 3'd0;
    case (state_q)
      S_MUL:   red_in_d = {1'b0, ra_q} * {1'b0, rb_q};
      S_ACC:   red_in_d = {1'b0, acc_q} + {1'b0, p_q};
      default: red_in_d = 3'd0;
    endcase
  end

  GFE_barret u_red (
    .x_i (red_in_d),
    .r_o (red_out)
  );

  // Sequencer FSM with registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ra_q       <= 2'd0;
      rb_q       <= 2'd0;
      p_q        <= 2'd0;
      acc_q      <= 2'd0;
      cnt_q      <= '0;
      result_q   <= 2'd0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            acc_q      <= 2'd0;
            cnt_q      <= '0;
            state_q    <= S_LOAD;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            ra_q       <= norm(a);
            rb_q       <= norm(b);
            state_q    <= S_MUL;
            in_ready_q <= 1'b0;
          end
        end
        S_MUL: begin
          p_q     <= red_out;
          state_q <= S_ACC;
        end
        S_ACC: begin
          acc_q <= red_out;
          if (cnt_q == LAST) begin
            result_q <= red_out;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            cnt_q      <= cnt_q + 1'b1;
            in_ready_q <= 1'b1;
            state_q    <= S_LOAD;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;

endmodule

// File: tb/tb_gfe_dot_ctrl.sv
// Bench for gfe_dot_ctrl: two instances (LEN=4 and LEN=2), scoreboard of expected results.
// Expected results come from a plain mod-3 arithmetic model pushed when a run starts.
// Completed results are popped and compared when done pulses.
module tb_gfe_dot_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] start_v = 2'b11;
  logic [1:0] in_valid_v = 2'b11;
  logic [1:0] a = 2'd0;
  logic [1:0] b = 2'd0;
  logic [1:0] in_ready_v, busy_v, done_v;
  logic [1:0][1:0] res_v;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_seen [2] = '{0, 0};
  logic [1:0] sbq0 [$];
  logic [1:0] sbq1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  gfe_dot_ctrl #(.LEN(4), .CW(4)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .in_valid(in_valid_v[0]),
    .in_ready(in_ready_v[0]), .a(a), .b(b), .busy(busy_v[0]),
    .done(done_v[0]), .result(res_v[0])
  );

  gfe_dot_ctrl #(.LEN(2), .CW(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .in_valid(in_valid_v[1]),
    .in_ready(in_ready_v[1]), .a(a), .b(b), .busy(busy_v[1]),
    .done(done_v[1]), .result(res_v[1])
  );

  // Scoreboard consumer: every done pulse pops one expected result
  always @(negedge clk) begin
    logic [1:0] e;
    for (int d = 0; d < 2; d++) begin
      if (done_v[d] === 1'b1 && !rst) begin
        done_seen[d]++;
        checks++;
        if ((d == 0 && sbq0.size() == 0) || (d == 1 && sbq1.size() == 0)) begin
          errors++;
          $display("FAIL unexpected_done dut%0d: got done=1 result=%0d, required no done", d, res_v[d]);
        end else begin
          if (d == 0) e = sbq0.pop_front();
          else        e = sbq1.pop_front();
          if (res_v[d] !== e) begin
            errors++;
            $display("FAIL result dut%0d: got %0d, required %0d", d, res_v[d], e);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of run, required finish");
    $fatal(1, "watchdog");
  end

  function automatic int nrm(input logic [1:0] v);
    return (v == 2'b11) ? 0 : int'(v);
  endfunction

  task automatic run_dot(input int d, input int n, input logic [1:0] av [4],
                         input logic [1:0] bv [4], input int stall_mask,
                         input bit extra_start, input bit chk_acc, input int exp_lat,
                         input string name);
    int macc;
    int accs [4];
    int seen0, t0, t;
    macc = 0;
    for (int k = 0; k < n; k++) begin
      macc = (macc + (nrm(av[k]) * nrm(bv[k])) % 3) % 3;
      accs[k] = macc;
    end
    if (d == 0) sbq0.push_back(2'(macc));
    else        sbq1.push_back(2'(macc));
    seen0 = done_seen[d];

    @(negedge clk); start_v[d] = 1'b1;
    @(negedge clk); start_v[d] = 1'b0;
    t0 = cyc;
    checks++;
    if (busy_v[d] !== 1'b1 || in_ready_v[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s_start: got busy=%b in_ready=%b, required 1 1", name, busy_v[d], in_ready_v[d]);
    end

    for (int k = 0; k < n; k++) begin
      if (stall_mask[k]) begin
        in_valid_v[d] = 1'b0;
        t = 0;
        while (in_ready_v[d] !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        repeat (3) begin
          checks++;
          if (in_ready_v[d] !== 1'b1) begin
            errors++;
            $display("FAIL %s_stall_ready: got in_ready=%b, required 1", name, in_ready_v[d]);
          end
          @(negedge clk);
        end
      end
      if (extra_start && k == 2) begin
        start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
      end
      a = av[k];
      b = bv[k];
      in_valid_v[d] = 1'b1;
      t = 0;
      while (in_ready_v[d] !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin
        errors++;
        $display("FAIL %s_ready_timeout: got in_ready=0 for 50 cycles, required 1", name);
        in_valid_v[d] = 1'b0;
        return;
      end
      if (chk_acc && d == 0 && k > 0) begin
        checks++;
        if (int'(u_dut0.acc_q) !== accs[k-1]) begin
          errors++;
          $display("FAIL %s_acc%0d: got %0d, required %0d", name, k - 1, u_dut0.acc_q, accs[k-1]);
        end
      end
      @(negedge clk);
    end
    in_valid_v[d] = 1'b0;

    t = 0;
    while (done_v[d] !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (t >= 50) begin
      errors++;
      $display("FAIL %s_done_timeout: got no done in 50 cycles, required done", name);
      return;
    end
    if (cyc - t0 !== exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d, required %0d", name, cyc - t0, exp_lat);
    end
    if (chk_acc && d == 0) begin
      checks++;
      if (int'(u_dut0.acc_q) !== accs[n-1]) begin
        errors++;
        $display("FAIL %s_acc%0d: got %0d, required %0d", name, n - 1, u_dut0.acc_q, accs[n-1]);
      end
    end
    @(negedge clk);
    checks++;
    if (done_v[d] !== 1'b0 || busy_v[d] !== 1'b0 || in_ready_v[d] !== 1'b0) begin
      errors++;
      $display("FAIL %s_after_done: got done=%b busy=%b in_ready=%b, required 0 0 0",
               name, done_v[d], busy_v[d], in_ready_v[d]);
    end
    checks++;
    if (done_seen[d] !== seen0 + 1) begin
      errors++;
      $display("FAIL %s_done_count: got %0d, required %0d", name, done_seen[d] - seen0, 1);
    end
  endtask

  task automatic test_reset();
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (in_ready_v !== 2'b00 || busy_v !== 2'b00 || done_v !== 2'b00 || res_v !== 4'h0) begin
        errors++;
        $display("FAIL reset_hold: got in_ready=%b busy=%b done=%b result=%h, required all 0",
                 in_ready_v, busy_v, done_v, res_v);
      end
    end
    rst = 1'b0;
    start_v = 2'b00;
    in_valid_v = 2'b00;
    @(negedge clk);
    checks++;
    if (busy_v !== 2'b00 || in_ready_v !== 2'b00 || res_v !== 4'h0) begin
      errors++;
      $display("FAIL reset_release: got busy=%b in_ready=%b result=%h, required idle zeros",
               busy_v, in_ready_v, res_v);
    end
  endtask

  task automatic test_mixed();
    logic [1:0] av [4] = '{2'd1, 2'd2, 2'd2, 2'd1};
    logic [1:0] bv [4] = '{2'd1, 2'd2, 2'd1, 2'd0};
    run_dot(0, 4, av, bv, 0, 1'b0, 1'b0, 12, "mixed");
  endtask

  task automatic test_all_twos();
    logic [1:0] av [4] = '{2'd2, 2'd2, 2'd2, 2'd2};
    logic [1:0] bv [4] = '{2'd2, 2'd2, 2'd2, 2'd2};
    run_dot(0, 4, av, bv, 0, 1'b0, 1'b1, 12, "twos");
  endtask

  task automatic test_stall();
    logic [1:0] av [4] = '{2'd1, 2'd2, 2'd2, 2'd1};
    logic [1:0] bv [4] = '{2'd1, 2'd2, 2'd1, 2'd0};
    run_dot(0, 4, av, bv, 32'b1010, 1'b0, 1'b0, 18, "stall");
  endtask

  task automatic test_illegal();
    logic [1:0] av [4] = '{2'd3, 2'd2, 2'd0, 2'd0};
    logic [1:0] bv [4] = '{2'd2, 2'd1, 2'd0, 2'd0};
    run_dot(1, 2, av, bv, 0, 1'b0, 1'b0, 6, "illegal");
  endtask

  task automatic test_reset_mid();
    int seen0;
    int t;
    seen0 = done_seen[0];
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    a = 2'd1; b = 2'd2; in_valid_v[0] = 1'b1;
    @(negedge clk);
    t = 0;
    while (in_ready_v[0] !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    @(negedge clk);
    rst = 1'b1;
    in_valid_v[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (res_v[0] !== 2'd0 || busy_v[0] !== 1'b0 || in_ready_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got result=%0d busy=%b in_ready=%b done=%b, required 0 0 0 0",
               res_v[0], busy_v[0], in_ready_v[0], done_v[0]);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (done_seen[0] !== seen0 || res_v[0] !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got %0d done pulses result=%0d, required 0 pulses result 0",
               done_seen[0] - seen0, res_v[0]);
    end
  endtask

  task automatic test_ignored_start();
    logic [1:0] av [4] = '{2'd1, 2'd1, 2'd1, 2'd0};
    logic [1:0] bv [4] = '{2'd2, 2'd2, 2'd2, 2'd0};
    run_dot(0, 4, av, bv, 0, 1'b1, 1'b1, 12, "ignored_start");
  endtask

  initial begin
    test_reset();
    test_mixed();
    test_all_twos();
    test_stall();
    test_illegal();
    test_reset_mid();
    test_ignored_start();
    repeat (3) @(negedge clk);
    checks++;
    if (sbq0.size() != 0 || sbq1.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending, required 0/0", sbq0.size(), sbq1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gfe_dot_ctrl.md
# gfe_dot_ctrl

Sequencer that computes a GF(3) dot product over LEN operand pairs using one shared instance of the mod-3 Barrett reducer `GFE_barret`. The reducer is time-multiplexed each pair: first for the product reduction, then for the accumulate reduction. It sits between an operand stream source and the consumer of the 2-bit GF(3) result, and is the sequencing/scheduling layer for the reducer datapath.

## Interface
- LEN, default 4: number of operand pairs per dot product; legal range 1..15.
- CW, default 4: width of the pair counter; must satisfy 2^CW > LEN-1.

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a new dot product; sampled only in IDLE
- in_valid  in  1  operand pair a/b is valid
- in_ready  out  1  block accepts a pair this cycle
- a  in  2  GF(3) operand
- b  in  2  GF(3) operand
- busy  out  1  high in LOAD, MUL, ACC and DONE
- done  out  1  one-cycle pulse when result is updated
- result  out  2  last completed dot product, in {0,1,2}

## Operation
- One clock; reset is synchronous and active-high.
- Internal registers:
  - `ra` and `rb` (2 bits each), the captured operands.
  - `p` (2 bits), the reduced product.
  - `acc` (2 bits), the running sum.
  - `cnt` (CW bits), the pair counter.
- Exactly one `GFE_barret` instance. Its 3-bit input mux selects by state:
  - MUL: `ra*rb` (0..4).
  - ACC: `acc+p` (0..4).
  - All other states: 0.
- Operand normalisation at capture: an input value of 2'b11 is stored as 0, because 3 mod 3 = 0. Values 0, 1 and 2 are stored unchanged.
- States and transitions:
  - IDLE:
    - start=1 moves to LOAD, clearing `acc` and `cnt`.
    - Otherwise stays in IDLE.
  - LOAD:
    - in_ready=1.
    - in_valid=1 captures the normalised a/b into `ra`/`rb` and moves to MUL.
    - in_valid=0 stays in LOAD.
  - MUL: `p` ← reducer output; moves to ACC.
  - ACC: `acc` ← reducer output.
    - If cnt==LEN-1: `result` ← reducer output, then move to DONE.
    - Otherwise: cnt ← cnt+1, then move to LOAD.
  - DONE: done=1 for this cycle only; moves to IDLE unconditionally.
- start is ignored in every state except IDLE. An in_valid while in_ready=0 is not consumed.
- `result` holds its value from the completing ACC until the next completing ACC. It is unaffected by a new start.
- in_ready is a pure decode of state (LOAD) and has no combinational path from in_valid.
- Arithmetic:
  - Products and sums are computed at 3-bit width before reduction; the maximum reducer input is 4.
  - The reducer output is always in {0,1,2}.

## Timing
- Reset values: state=IDLE, in_ready=0, busy=0, done=0, result=0; `acc`, `p`, `cnt`, `ra` and `rb` are all 0.
- Reset asserted in any state returns to IDLE on the next edge:
  - The partial `acc` is discarded and `result` is cleared to 0.
  - done is not pulsed.
- Per-pair cost is 3 cycles (LOAD, MUL, ACC) plus any LOAD stall cycles.
- Edge numbering when in_valid is held high: start is sampled at edge E0.
  - Pair k is accepted at edge E(1+3k).
  - The last ACC update happens at edge E(3·LEN).
  - done=1 and the new result are visible in the cycle following E(3·LEN). For LEN=4 that is 12 cycles after the start edge.
- A new start is accepted in the cycle after DONE at the earliest, since the FSM is back in IDLE by then.
- LEN=1 boundary: the sequence is LOAD, MUL, ACC, then DONE directly, with no counter increment.

## Test plan
- Reset check:
  - Stimulus: hold rst for 2 cycles with start=1 and in_valid=1.
  - Required: in_ready=0, busy=0, done=0 and result=0 throughout; IDLE after release.
- Mixed operands, no stalls:
  - Stimulus: LEN=4, pairs (1,1), (2,2), (2,1), (1,0), in_valid held high.
  - Required: single done pulse 12 cycles after the start edge; result=1, from 1+1+2+0 = 4 mod 3.
- All twos:
  - Stimulus: LEN=4, all pairs (2,2).
  - Required: acc sequence 1, 2, 0, 1; result=1.
- Stalled input:
  - Stimulus: same pairs as the mixed-operand case, with in_valid deasserted for 3 cycles before pairs 2 and 4.
  - Required: in_ready stays high during the stalls; result=1; done arrives 6 cycles later than in the unstalled run.
- Illegal-operand normalisation:
  - Stimulus: LEN=2, pairs (3,2), (2,1).
  - Required: the first pair contributes 0; result=2.
- Reset mid-operation and ignored start:
  - Stimulus: assert rst in the MUL state of pair 2; then run LEN=4 with pairs (1,2), (1,2), (1,2), (0,0); pulse start during that run.
  - Required: after the reset, result=0 and no done pulse. The extra start has no effect. The run ends with result=0, from 2+2+2 = 6 mod 3.
